dot_product_acc: RTL

DOT_PRODUCT_ACC -- requirements
Module: dot_product_acc

---
 rtl/dot_product_acc.sv | 97 +++++++++
 1 files changed

// File: rtl/dot_product_acc.sv
// Streaming accumulator for a dot product: sums len unsigned 64-bit products
// into an ACC_W-bit register and presents the total on a valid/ready output.
module dot_product_acc #(
    parameter int ACC_W = 72,
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             in_valid,
    input  logic [63:0]      in_prod,
    output logic             in_ready,
    output logic             out_valid,
    output logic [ACC_W-1:0] out_sum,
    input  logic             out_ready,
    output logic             busy,
    output logic             overflow,
    output logic [1:0]       dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; ready never depends on the partner's valid.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic             ovf_q, ovf_d;
    logic [ACC_W:0]   sum_w;

    // One extra bit on the adder captures the carry out of the accumulator.
    assign sum_w = {1'b0, acc_q} + {{(ACC_W + 1 - 64){1'b0}}, in_prod};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            rem_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        rem_d   = rem_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    acc_d   = '0;
                    ovf_d   = 1'b0;
                    rem_d   = len;
                    state_d = (len != '0) ? ACCUM : DONE;
                end
            end
            ACCUM: begin
                if (in_valid) begin
                    acc_d = sum_w[ACC_W-1:0];
                    if (sum_w[ACC_W]) begin
                        ovf_d = 1'b1;
                    end
                    rem_d = rem_q - LEN_W'(1);
                    if (rem_q == LEN_W'(1)) begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign in_ready  = (state_q == ACCUM);
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_sum   = acc_q;
    assign overflow  = ovf_q;
    assign dbg_state = state_q;

endmodule
